// File: rtl/sd_sector_write_scheduler.sv
// sd_sector_write_scheduler: buffers a UART byte stream into two ping-pong
// sector banks. Each full or flushed bank is handed to the SD write
// controller as one sector write, at consecutive sector addresses.
module sd_sector_write_scheduler #(
    parameter logic [31:0] START_SECTOR = 32'd16000,
    parameter int          SECTOR_BYTES = 512,
    parameter logic [7:0]  FLUSH_PAD    = 8'h00,
    parameter int          BUSY_TIMEOUT = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        flush_req,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    input  logic        wr_busy,
    input  logic        wr_data_req,
    output logic [7:0]  wr_data,
    output logic [1:0]  bank_full,
    output logic        overflow,
    output logic [31:0] sectors_written
);

    localparam int AW = $clog2(SECTOR_BYTES);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        XFER,
        DONE
    } drainState_t;

    // Both banks live in one array; the bank number is the top address bit.
    logic [7:0]    r_mem [0:2*SECTOR_BYTES-1];

    logic          r_fillBank;
    logic [AW-1:0] r_fillCnt;
    logic [AW:0]   r_len [0:1];
    logic [1:0]    r_bankFull;
    logic          r_overflow;
    logic          r_flushPend;

    drainState_t   r_state;
    logic          r_drainBank;
    logic [AW-1:0] r_rdIdx;
    logic [TW-1:0] r_timer;
    logic          r_wrReq;
    logic [31:0]   r_wrAddr;
    logic [7:0]    r_wrData;
    logic [31:0]   r_sectors;

    logic          w_fillFull;
    logic          w_byteAccept;
    logic          w_flushAny;
    logic          w_byteCompletes;
    logic [AW:0]   w_fillLen;
    logic          w_flushClose;
    logic          w_close;
    logic          w_doneClear;

    // A bank can only be closed while it is still the (non-full) fill bank.
    // The closing length counts a byte stored in the same cycle as the flush.
    assign w_fillFull      = r_bankFull[r_fillBank];
    assign w_byteAccept    = byte_valid & ~w_fillFull;
    assign w_flushAny      = flush_req | r_flushPend;
    assign w_byteCompletes = w_byteAccept && (r_fillCnt == AW'(SECTOR_BYTES - 1));
    assign w_fillLen       = {1'b0, r_fillCnt} + {{AW{1'b0}}, w_byteAccept};
    assign w_flushClose    = ~w_fillFull & w_flushAny & ~w_byteCompletes & (w_fillLen != '0);
    assign w_close         = w_byteCompletes | w_flushClose;
    assign w_doneClear     = (r_state == DONE);

    // Sector storage: accepted bytes land at the fill position of the fill bank.
    always_ff @(posedge sys_clk) begin
        if (w_byteAccept) begin
            r_mem[{r_fillBank, r_fillCnt}] <= byte_data;
        end
    end

    // Fill side: count bytes, close banks on a full sector or flush, flag drops.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fillBank  <= 1'b0;
            r_fillCnt   <= '0;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_bankFull  <= 2'b00;
            r_overflow  <= 1'b0;
            r_flushPend <= 1'b0;
        end else begin
            if (byte_valid && w_fillFull) begin
                r_overflow <= 1'b1;
            end
            if (w_fillFull) begin
                if (flush_req) begin
                    r_flushPend <= 1'b1;
                end
            end else if (w_close) begin
                r_bankFull[r_fillBank] <= 1'b1;
                r_len[r_fillBank]      <= w_fillLen;
                r_fillBank             <= ~r_fillBank;
                r_fillCnt              <= '0;
                r_flushPend            <= 1'b0;
            end else begin
                if (w_byteAccept) begin
                    r_fillCnt <= r_fillCnt + AW'(1);
                end
                if (w_flushAny) begin
                    r_flushPend <= 1'b0;
                end
            end
            if (w_doneClear) begin
                r_bankFull[r_drainBank] <= 1'b0;
            end
        end
    end

    // Drain FSM: issue the sector write, serve byte requests, retire the bank.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_drainBank <= 1'b0;
            r_rdIdx     <= '0;
            r_timer     <= '0;
            r_wrReq     <= 1'b0;
            r_wrAddr    <= START_SECTOR;
            r_wrData    <= 8'h00;
            r_sectors   <= 32'd0;
        end else begin
            r_wrReq <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_end && r_bankFull[r_drainBank]) begin
                        r_state <= ISSUE;
                        r_wrReq <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_timer <= '0;
                end
                WAIT: begin
                    if (wr_busy) begin
                        r_state <= XFER;
                    end else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
                        r_state <= ISSUE;
                        r_wrReq <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                XFER: begin
                    if (wr_data_req) begin
                        r_wrData <= ({1'b0, r_rdIdx} < r_len[r_drainBank]) ?
                                    r_mem[{r_drainBank, r_rdIdx}] : FLUSH_PAD;
                        if (r_rdIdx != AW'(SECTOR_BYTES - 1)) begin
                            r_rdIdx <= r_rdIdx + AW'(1);
                        end
                    end
                    if (!wr_busy) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_drainBank <= ~r_drainBank;
                    r_rdIdx     <= '0;
                    r_wrAddr    <= r_wrAddr + 32'd1;
                    r_sectors   <= r_sectors + 32'd1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_req          = r_wrReq;
    assign wr_addr         = r_wrAddr;
    assign wr_data         = r_wrData;
    assign bank_full       = r_bankFull;
    assign overflow        = r_overflow;
    assign sectors_written = r_sectors;

endmodule

// File: tb/tb_sd_sector_write_scheduler.sv
// tb_sd_sector_write_scheduler: drives byte streams and flushes, plays the SD
// write controller, and compares returned sector bytes against a queue of
// the bytes that were sent.
module tb_sd_sector_write_scheduler;

    localparam int          SB    = 512;
    localparam int          BT    = 1000;
    localparam logic [31:0] START = 32'd16000;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        init_end    = 1'b0;
    logic        byte_valid  = 1'b0;
    logic [7:0]  byte_data   = 8'h00;
    logic        flush_req   = 1'b0;
    logic        wr_busy     = 1'b0;
    logic        wr_data_req = 1'b0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  bank_full;
    logic        overflow;
    logic [31:0] sectors_written;

    typedef struct {
        string      name;
        int         nBytes;
        bit         flushEnd;
        bit         mergeFlush;
        bit         incPattern;
        int         writes;
        int         lastLen;
        logic [1:0] expFull;
        logic       expOvf;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] expQ [$];
    int         nApplied = 0;
    int         nMiss    = 0;
    int         reqCount = 0;

    sd_sector_write_scheduler dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .init_end        (init_end),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .flush_req       (flush_req),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_busy         (wr_busy),
        .wr_data_req     (wr_data_req),
        .wr_data         (wr_data),
        .bank_full       (bank_full),
        .overflow        (overflow),
        .sectors_written (sectors_written)
    );

    // 50 MHz system clock.
    always #10 sys_clk = ~sys_clk;

    // Count every cycle wr_req is seen high, so extra or missing commands show up.
    always @(negedge sys_clk) begin
        if (sys_rst_n && wr_req) reqCount++;
    end

    // Hard stop in case some wait escapes its own bound.
    initial begin
        #(20 * 90000);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        sys_rst_n   = 1'b0;
        byte_valid  = 1'b0;
        flush_req   = 1'b0;
        wr_busy     = 1'b0;
        wr_data_req = 1'b0;
        init_end    = 1'b0;
        expQ.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Send n back-to-back bytes, pushing each into the expected queue.
    task automatic applyStimulus(input int n, input bit flushEnd, input bit merge, input bit inc);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = inc ? 8'(i) : 8'($urandom_range(0, 255));
            flush_req  = merge && (i == n - 1);
            expQ.push_back(byte_data);
            @(negedge sys_clk);
        end
        byte_valid = 1'b0;
        flush_req  = 1'b0;
        if (flushEnd && !merge) begin
            flush_req = 1'b1;
            @(negedge sys_clk);
            flush_req = 1'b0;
        end
    endtask

    // Behave as the SD write controller for one sector; optionally stop mid-transfer.
    task automatic sdWrite(input logic [31:0] addr, input int len, input int nreq, input bit finish);
        int         waited;
        logic [7:0] exp;
        waited = 0;
        while (!wr_req && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        checkOutput("wr_req seen", {31'b0, wr_req}, 32'd1);
        if (!wr_req) return;
        checkOutput("wr_addr", wr_addr, addr);
        wr_busy = 1'b1;
        @(negedge sys_clk);
        checkOutput("wr_req one cycle", {31'b0, wr_req}, 32'd0);
        @(negedge sys_clk);
        wr_data_req = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            @(negedge sys_clk);
            exp = 8'h00;
            if (i < len) begin
                if (expQ.size() > 0) exp = expQ.pop_front();
                else exp = ~wr_data;
            end
            checkOutput($sformatf("wr_data[%0d]", i), {24'b0, wr_data}, {24'b0, exp});
        end
        wr_data_req = 1'b0;
        if (!finish) return;
        wr_busy = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic applyVector(input vec_t v);
        int startReq;
        doReset();
        init_end = 1'b1;
        startReq = reqCount;
        fork
            applyStimulus(v.nBytes, v.flushEnd, v.mergeFlush, v.incPattern);
            begin
                for (int w = 0; w < v.writes; w++)
                    sdWrite(START + 32'(w), (w == v.writes - 1) ? v.lastLen : SB, SB, 1'b1);
            end
        join
        repeat (20) @(negedge sys_clk);
        checkOutput($sformatf("%s reqs", v.name), 32'(reqCount - startReq), 32'(v.writes));
        checkOutput($sformatf("%s sectors", v.name), sectors_written, 32'(v.writes));
        checkOutput($sformatf("%s next addr", v.name), wr_addr, START + 32'(v.writes));
        checkOutput($sformatf("%s bank_full", v.name), {30'b0, bank_full}, {30'b0, v.expFull});
        checkOutput($sformatf("%s overflow", v.name), {31'b0, overflow}, {31'b0, v.expOvf});
        checkOutput($sformatf("%s leftover", v.name), 32'(expQ.size()), 32'd0);
    endtask

    // Main sequence: reset state, vector table, then multi-cycle corner cases.
    initial begin
        int startReq;
        int t0;
        int t1;
        int cyc;

        vecs[0] = '{"seq512",     512,  1'b0, 1'b0, 1'b1, 1, 512, 2'b00, 1'b0};
        vecs[1] = '{"b2b1024",    1024, 1'b0, 1'b0, 1'b0, 2, 512, 2'b00, 1'b0};
        vecs[2] = '{"flush10",    10,   1'b1, 1'b0, 1'b0, 1, 10,  2'b00, 1'b0};
        vecs[3] = '{"flushAt511", 512,  1'b1, 1'b1, 1'b0, 1, 512, 2'b00, 1'b0};
        vecs[4] = '{"flush700",   700,  1'b1, 1'b0, 1'b0, 2, 188, 2'b00, 1'b0};
        vecs[5] = '{"flushEmpty", 0,    1'b1, 1'b0, 1'b0, 0, 0,   2'b00, 1'b0};
        vecs[6] = '{"flushOne",   1,    1'b1, 1'b1, 1'b0, 1, 1,   2'b00, 1'b0};

        doReset();
        checkOutput("rst wr_req", {31'b0, wr_req}, 32'd0);
        checkOutput("rst wr_addr", wr_addr, START);
        checkOutput("rst wr_data", {24'b0, wr_data}, 32'd0);
        checkOutput("rst bank_full", {30'b0, bank_full}, 32'd0);
        checkOutput("rst overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst sectors", sectors_written, 32'd0);

        for (int i = 0; i < 7; i++) applyVector(vecs[i]);

        $display("[TB] init_end low holds off the write");
        doReset();
        startReq = reqCount;
        applyStimulus(SB, 1'b0, 1'b0, 1'b0);
        repeat (50) @(negedge sys_clk);
        checkOutput("noinit reqs", 32'(reqCount - startReq), 32'd0);
        checkOutput("noinit bank_full", {30'b0, bank_full}, 32'd1);
        init_end = 1'b1;
        sdWrite(START, SB, SB, 1'b1);
        checkOutput("noinit sectors", sectors_written, 32'd1);

        $display("[TB] busy never rises: overflow and re-issue");
        doReset();
        init_end = 1'b1;
        applyStimulus(1100, 1'b0, 1'b0, 1'b0);
        expQ.delete();
        checkOutput("ovf bank_full", {30'b0, bank_full}, 32'd3);
        checkOutput("ovf overflow", {31'b0, overflow}, 32'd1);
        t0  = -1;
        t1  = -1;
        cyc = 0;
        while (t1 < 0 && cyc < 2600) begin
            if (wr_req) begin
                if (t0 < 0) t0 = cyc;
                else t1 = cyc;
            end
            @(negedge sys_clk);
            cyc++;
        end
        checkOutput("reissue gap", {31'b0, (t1 >= 0 && (t1 - t0) >= BT && (t1 - t0) <= BT + 1)}, 32'd1);
        checkOutput("reissue addr", wr_addr, START);
        checkOutput("ovf sectors", sectors_written, 32'd0);
        checkOutput("ovf sticky", {31'b0, overflow}, 32'd1);

        $display("[TB] reset during transfer");
        doReset();
        init_end = 1'b1;
        fork
            applyStimulus(2 * SB, 1'b0, 1'b0, 1'b1);
            begin
                sdWrite(START, SB, SB, 1'b1);
                sdWrite(START + 32'd1, SB, 100, 1'b0);
            end
        join
        sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst wr_req", {31'b0, wr_req}, 32'd0);
        checkOutput("midrst wr_addr", wr_addr, START);
        checkOutput("midrst wr_data", {24'b0, wr_data}, 32'd0);
        checkOutput("midrst bank_full", {30'b0, bank_full}, 32'd0);
        checkOutput("midrst overflow", {31'b0, overflow}, 32'd0);
        checkOutput("midrst sectors", sectors_written, 32'd0);
        wr_busy     = 1'b0;
        wr_data_req = 1'b0;
        expQ.delete();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        fork
            applyStimulus(SB, 1'b0, 1'b0, 1'b1);
            sdWrite(START, SB, SB, 1'b1);
        join
        checkOutput("postrst sectors", sectors_written, 32'd1);
        checkOutput("postrst next addr", wr_addr, START + 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
